// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage for the pipelined LEGv8 core. Owns the
//            64-bit program counter, drives it to instruction memory, captures
//            the returned word into a small fetch queue, and hands
//            {pc, instruction} pairs to decode over a valid/ready handshake.
//            Execute-stage redirects reload the PC and flush the queue.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   RESET_PC        PC value loaded on reset
//   DEPTH           fetch-queue entries (power of two, >= 2)
// Ports:
//   clk             single clock, rising edge
//   rst             synchronous active-high reset
//   pc              [63:0] fetch address to instruction memory (registered)
//   instruction     [31:0] memory read data for the current pc (same cycle)
//   redirect        taken branch/jump from execute
//   redirect_target [63:0] new PC when redirect=1 (low two bits dropped)
//   if_valid        queue head holds a valid entry
//   if_ready        decode accepts the head this cycle
//   if_instr        [31:0] head instruction, 0 when if_valid=0
//   if_pc           [63:0] head PC, 0 when if_valid=0
//   stall_cycles    [31:0] saturating count of cycles with if_valid && !if_ready
//                   (present only when FETCH_PERF_COUNT_EN is defined)
// Build option:
//   FETCH_PERF_COUNT_EN  adds the stall_cycles performance counter
// ============================================================================
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc,
  input  logic [31:0] instruction,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [63:0]        r_pc;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [63:0]        r_q_pc    [DEPTH];
  logic [31:0]        r_q_instr [DEPTH];

  logic               w_push;
  logic               w_pop;
  logic [c_CNT_W-1:0] w_push_inc;
  logic [c_CNT_W-1:0] w_pop_dec;

  // The full test uses the occupancy from before this cycle's pop, so a
  // drain and a refill never overlap on a full queue. That keeps the tail
  // from ever landing on the entry currently presented at the head.
  assign w_push = !redirect && (r_count < c_DEPTH);
  assign w_pop  = if_valid && if_ready;

  assign w_push_inc = {{c_PTR_W{1'b0}}, w_push};
  assign w_pop_dec  = {{c_PTR_W{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else if (redirect) begin
      // Flush: whatever was queued belongs to the wrong path, including an
      // entry decode may be accepting this very cycle.
      r_pc    <= {redirect_target[63:2], 2'b00};
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_push) begin
        r_q_pc[r_tail]    <= r_pc;
        r_q_instr[r_tail] <= instruction;
        r_tail            <= r_tail + c_PTR_W'(1);
        r_pc              <= r_pc + 64'd4;  // wraps modulo 2^64
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_W'(1);
      end
      r_count <= r_count + w_push_inc - w_pop_dec;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pc       = r_pc;
  assign if_valid = (r_count != '0);
  // Stale storage stays hidden from decode when the queue is empty.
  assign if_instr = r_q_instr[r_head] & {32{if_valid}};
  assign if_pc    = r_q_pc[r_head]    & {64{if_valid}};

`ifdef FETCH_PERF_COUNT_EN
  // --------------------------------------------------------------------------
  // Stall counter: cycles where decode is offered an entry but refuses it.
  // Deliberately independent of redirect so it measures decode back-pressure.
  // --------------------------------------------------------------------------
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (if_valid && !if_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. A queue-based reference
//            model predicts pc and the decode-side outputs every cycle, with
//            directed scenarios followed by randomized redirect/ready/reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          DEPTH    = 2;

  typedef struct packed {
    logic [63:0] epc;
    logic [31:0] ins;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [63:0] pc;
  logic [31:0] instruction;
  logic        redirect;
  logic [63:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [63:0] m_pc;
  ent_t        m_q[$];
  logic [31:0] m_stall;
  bit          chk_en;

  // Instruction memory: the four test-plan words at 0..C, a hash elsewhere.
  function automatic logic [31:0] imem(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h8b1f03e5;
      64'h4:   return 32'hf84000a4;
      64'h8:   return 32'h8b040086;
      64'hC:   return 32'hf80010a6;
      default: return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0000;
    endcase
  endfunction

  assign instruction = imem(pc);

  fetch_stage #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .instruction    (instruction),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance
  // the model by the cycle's rules, then move past the rising edge.
  task automatic step(input logic r, input logic rd, input logic [63:0] tgt, input logic rdy);
    bit can_push;
    rst             = r;
    redirect        = rd;
    redirect_target = tgt;
    if_ready        = rdy;
    #1;
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("if_valid", {63'd0, if_valid}, {63'd0, m_q.size() != 0});
      check("if_pc", if_pc, (m_q.size() != 0) ? m_q[0].epc : 64'd0);
      check("if_instr", {32'd0, if_instr}, {32'd0, (m_q.size() != 0) ? m_q[0].ins : 32'd0});
`ifdef FETCH_PERF_COUNT_EN
      check("stall_cycles", {32'd0, stall_cycles}, {32'd0, m_stall});
`endif
    end
    if (r) begin
      m_pc = RESET_PC;
      m_q.delete();
      m_stall = 32'd0;
    end else begin
      if (m_q.size() != 0 && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (rd) begin
        m_q.delete();
        m_pc = {tgt[63:2], 2'b00};
      end else begin
        can_push = (m_q.size() < DEPTH);
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (can_push) begin
          m_q.push_back('{epc: m_pc, ins: imem(m_pc)});
          m_pc = m_pc + 64'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    if (r) chk_en = 1'b1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 64'd0, 1'b0);
    step(1'b1, 1'b0, 64'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] words [4];
    logic [63:0] tgt;
    words[0] = 32'h8b1f03e5;
    words[1] = 32'hf84000a4;
    words[2] = 32'h8b040086;
    words[3] = 32'hf80010a6;
    chk_en = 1'b0;
    m_pc = RESET_PC;
    m_stall = 32'd0;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_target = 64'd0;
    if_ready = 1'b0;

    // ---- Reset and stream ------------------------------------------------
    do_reset();
    check("rst_pc", pc, RESET_PC);
    check("rst_valid", {63'd0, if_valid}, 64'd0);
    check("rst_instr", {32'd0, if_instr}, 64'd0);
    check("rst_ifpc", if_pc, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 64'd0, 1'b1);
      check("stream_valid", {63'd0, if_valid}, 64'd1);
      check("stream_pc", if_pc, 64'(i * 4));
      check("stream_instr", {32'd0, if_instr}, {32'd0, words[i]});
    end

    // ---- Backpressure ----------------------------------------------------
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 64'd0, 1'b0);
      check("bp_head_pc", if_pc, 64'h0);
      check("bp_head_instr", {32'd0, if_instr}, 64'h8b1f03e5);
    end
    check("bp_pc_frozen", pc, 64'h8);
    for (int i = 0; i < 3; i++) begin
      check("bp_drain_pc", if_pc, 64'(i * 4));
      check("bp_drain_instr", {32'd0, if_instr}, {32'd0, words[i]});
      step(1'b0, 1'b0, 64'd0, 1'b1);
    end

    // ---- Redirect while full --------------------------------------------
    do_reset();
    step(1'b0, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0);
    step(1'b0, 1'b1, 64'h40, 1'b1);
    check("redir_valid", {63'd0, if_valid}, 64'd0);
    check("redir_pc", pc, 64'h40);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    check("redir_ifpc", if_pc, 64'h40);
    check("redir_ifvalid", {63'd0, if_valid}, 64'd1);

    // ---- Misaligned redirect and wrap ------------------------------------
    step(1'b0, 1'b1, 64'h43, 1'b1);
    check("misalign_pc", pc, 64'h40);
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    check("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b0, 64'd0, 1'b1);
    check("wrap_pc", pc, 64'h0);
    check("wrap_ifpc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // ---- Mid-operation reset with redirect -------------------------------
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'd0, 1'b1);
    step(1'b1, 1'b1, 64'h80, 1'b1);
    check("midrst_pc", pc, RESET_PC);
    check("midrst_valid", {63'd0, if_valid}, 64'd0);
    check("midrst_instr", {32'd0, if_instr}, 64'd0);

`ifdef FETCH_PERF_COUNT_EN
    // ---- Stall counter ---------------------------------------------------
    do_reset();
    step(1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 64'd0, 1'b0);
    check("perf_seven", {32'd0, stall_cycles}, 64'd7);
    step(1'b0, 1'b1, 64'h40, 1'b1);
    check("perf_redirect", {32'd0, stall_cycles}, 64'd7);
    step(1'b1, 1'b0, 64'd0, 1'b0);
    check("perf_rst", {32'd0, stall_cycles}, 64'd0);
`endif

    // ---- Randomized traffic ----------------------------------------------
    do_reset();
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       tgt = {32'hFFFF_FFFF, 24'hFF_FFFF, 8'($urandom)};
        1:       tgt = 64'($urandom_range(0, 255));
        default: tgt = {$urandom, $urandom};
      endcase
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 7) == 0),
           tgt,
           ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
